// File: rtl/io_responder.sv
// Peripheral-side responder for the core's port I/O bus: per-port input holding
// registers with fresh/overrun tracking and interrupt, plus an output {addr,data} FIFO.
module io_responder #(
    parameter int unsigned NUBITS = 16,
    parameter int unsigned NBIOIN = 2,
    parameter int unsigned NBIOOU = 2,
    parameter int unsigned ODEPTH = 4,
    parameter logic [(1<<NBIOIN)-1:0] ITRMSK = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [NUBITS-1:0]                io_in,
    input  logic [NBIOIN-1:0]                addr_in,
    input  logic                             req_in,
    input  logic [NUBITS-1:0]                io_out,
    input  logic [NBIOOU-1:0]                addr_out,
    input  logic                             out_en,
    output logic                             itr,
    input  logic [(1<<NBIOIN)*NUBITS-1:0]    ext_in_data,
    input  logic [(1<<NBIOIN)-1:0]           ext_in_vld,
    output logic [(1<<NBIOIN)-1:0]           fresh,
    output logic [(1<<NBIOIN)-1:0]           ovr_in,
    output logic [NUBITS-1:0]                ext_out_data,
    output logic [NBIOOU-1:0]                ext_out_addr,
    output logic                             ext_out_vld,
    input  logic                             ext_out_rdy,
    output logic                             ovr_out,
    input  logic                             clr_ovr
);

    localparam int unsigned NIN = 1 << NBIOIN;
    localparam int unsigned AW  = $clog2(ODEPTH);
    localparam int unsigned EW  = NBIOOU + NUBITS;

    // ---------------- input path ----------------
    logic [NUBITS-1:0] r_hold [NIN];
    logic [NIN-1:0]    r_fresh;
    logic [NIN-1:0]    r_ovr_in;
    logic              r_itr;

    logic [NIN-1:0]    w_rd;
    logic [NIN-1:0]    w_fresh_d;
    logic [NIN-1:0]    w_ovr_in_d;

    always_comb begin
        w_rd       = '0;
        w_fresh_d  = r_fresh;
        w_ovr_in_d = r_ovr_in;
        for (int unsigned k = 0; k < NIN; k++) begin
            w_rd[k] = req_in && (addr_in == NBIOIN'(k));
            // A producer update wins over a read clearing the flag
            if (ext_in_vld[k]) begin
                w_fresh_d[k] = 1'b1;
            end else if (w_rd[k]) begin
                w_fresh_d[k] = 1'b0;
            end
            if (ext_in_vld[k] && r_fresh[k] && !w_rd[k]) begin
                w_ovr_in_d[k] = 1'b1;
            end else if (clr_ovr) begin
                w_ovr_in_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NIN; k++) begin
                r_hold[k] <= '0;
            end
            r_fresh  <= '0;
            r_ovr_in <= '0;
            r_itr    <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NIN; k++) begin
                if (ext_in_vld[k]) begin
                    r_hold[k] <= ext_in_data[k*NUBITS +: NUBITS];
                end
            end
            r_fresh  <= w_fresh_d;
            r_ovr_in <= w_ovr_in_d;
            r_itr    <= |(ITRMSK & ~r_fresh & w_fresh_d);
        end
    end

    assign io_in  = r_hold[addr_in];
    assign fresh  = r_fresh;
    assign ovr_in = r_ovr_in;
    assign itr    = r_itr;

    // ---------------- output FIFO ----------------
    logic [EW-1:0] r_mem [ODEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          r_ovr_out;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [EW-1:0] w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && ext_out_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write
    assign w_push  = out_en && (!w_full || w_pop);
    assign w_drop  = out_en && w_full && !w_pop;
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {addr_out, io_out};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_ovr_out <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
            if (w_drop) begin
                r_ovr_out <= 1'b1;
            end else if (clr_ovr) begin
                r_ovr_out <= 1'b0;
            end
        end
    end

    // Head is masked when empty so stale or uninitialised entries never leak out
    assign ext_out_vld  = !w_empty;
    assign ext_out_data = w_empty ? '0 : w_head[NUBITS-1:0];
    assign ext_out_addr = w_empty ? '0 : w_head[EW-1:NUBITS];
    assign ovr_out      = r_ovr_out;

endmodule

// File: tb/tb_io_responder.sv
// Directed, table-driven bench for io_responder (NIN=4, ODEPTH=4, ITRMSK=4'b0010).
module tb_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] io_in;
    logic [1:0]  addr_in;
    logic        req_in;
    logic [15:0] io_out;
    logic [1:0]  addr_out;
    logic        out_en;
    logic        itr;
    logic [63:0] ext_in_data;
    logic [3:0]  ext_in_vld;
    logic [3:0]  fresh;
    logic [3:0]  ovr_in;
    logic [15:0] ext_out_data;
    logic [1:0]  ext_out_addr;
    logic        ext_out_vld;
    logic        ext_out_rdy;
    logic        ovr_out;
    logic        clr_ovr;

    int n_tests = 0;
    int n_fail  = 0;

    io_responder #(
        .NUBITS(16), .NBIOIN(2), .NBIOOU(2), .ODEPTH(4), .ITRMSK(4'b0010)
    ) dut (
        .clk(clk), .rst(rst), .io_in(io_in), .addr_in(addr_in), .req_in(req_in),
        .io_out(io_out), .addr_out(addr_out), .out_en(out_en), .itr(itr),
        .ext_in_data(ext_in_data), .ext_in_vld(ext_in_vld), .fresh(fresh),
        .ovr_in(ovr_in), .ext_out_data(ext_out_data), .ext_out_addr(ext_out_addr),
        .ext_out_vld(ext_out_vld), .ext_out_rdy(ext_out_rdy), .ovr_out(ovr_out),
        .clr_ovr(clr_ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [63:0] din;
        logic [1:0]  ain;
        logic        req;
        logic        oen;
        logic [1:0]  aout;
        logic [15:0] dout;
        logic        rdy;
        logic        clr;
        logic [15:0] e_io;     // io_in before the edge
        logic [3:0]  e_fresh;  // the rest after the edge
        logic [3:0]  e_ovin;
        logic        e_itr;
        logic        e_ovld;
        logic [1:0]  e_oaddr;
        logic [15:0] e_odata;
        logic        e_ovout;
    } vec_t;

    function automatic vec_t v(
        logic [3:0] vld, logic [63:0] din, logic [1:0] ain, logic req,
        logic oen, logic [1:0] aout, logic [15:0] dout, logic rdy, logic clr,
        logic [15:0] e_io, logic [3:0] e_fresh, logic [3:0] e_ovin, logic e_itr,
        logic e_ovld, logic [1:0] e_oaddr, logic [15:0] e_odata, logic e_ovout);
        vec_t r;
        r.vld = vld; r.din = din; r.ain = ain; r.req = req;
        r.oen = oen; r.aout = aout; r.dout = dout; r.rdy = rdy; r.clr = clr;
        r.e_io = e_io; r.e_fresh = e_fresh; r.e_ovin = e_ovin; r.e_itr = e_itr;
        r.e_ovld = e_ovld; r.e_oaddr = e_oaddr; r.e_odata = e_odata; r.e_ovout = e_ovout;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ext_in_vld = '0; ext_in_data = '0; addr_in = '0; req_in = 1'b0;
        out_en = 1'b0; addr_out = '0; io_out = '0; ext_out_rdy = 1'b0; clr_ovr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(string tag, logic e_vld, logic [1:0] e_addr, logic [15:0] e_data);
        chk({tag, ".vld"},  64'(ext_out_vld),  64'(e_vld));
        chk({tag, ".addr"}, 64'(ext_out_addr), 64'(e_addr));
        chk({tag, ".data"}, 64'(ext_out_data), 64'(e_data));
    endtask

    vec_t tbl [20];

    initial begin
        tbl[0]  = v(4'b0100, 64'h0000_1234_0000_0000, 0, 0, 0, 0, 0, 0, 0,
                    16'h0000, 4'b0100, 4'b0000, 0, 0, 0, 16'h0, 0);
        tbl[1]  = v(4'b0000, 64'h0, 2, 1, 0, 0, 0, 0, 0,
                    16'h1234, 4'b0000, 4'b0000, 0, 0, 0, 16'h0, 0);
        tbl[2]  = v(4'b0001, 64'h5, 0, 0, 0, 0, 0, 0, 0,
                    16'h0000, 4'b0001, 4'b0000, 0, 0, 0, 16'h0, 0);
        tbl[3]  = v(4'b0001, 64'h6, 0, 0, 0, 0, 0, 0, 0,
                    16'h0005, 4'b0001, 4'b0001, 0, 0, 0, 16'h0, 0);
        tbl[4]  = v(4'b0001, 64'h7, 0, 1, 0, 0, 0, 0, 0,
                    16'h0006, 4'b0001, 4'b0001, 0, 0, 0, 16'h0, 0);
        tbl[5]  = v(4'b0000, 64'h0, 0, 0, 0, 0, 0, 0, 1,
                    16'h0007, 4'b0001, 4'b0000, 0, 0, 0, 16'h0, 0);
        tbl[6]  = v(4'b0000, 64'h0, 0, 1, 0, 0, 0, 0, 0,
                    16'h0007, 4'b0000, 4'b0000, 0, 0, 0, 16'h0, 0);
        tbl[7]  = v(4'b0010, 64'h0011_0000, 1, 0, 0, 0, 0, 0, 0,
                    16'h0000, 4'b0010, 4'b0000, 1, 0, 0, 16'h0, 0);
        tbl[8]  = v(4'b0000, 64'h0, 1, 0, 0, 0, 0, 0, 0,
                    16'h0011, 4'b0010, 4'b0000, 0, 0, 0, 16'h0, 0);
        tbl[9]  = v(4'b0010, 64'h0022_0000, 1, 0, 0, 0, 0, 0, 0,
                    16'h0011, 4'b0010, 4'b0010, 0, 0, 0, 16'h0, 0);
        tbl[10] = v(4'b1000, 64'h0033_0000_0000_0000, 3, 0, 0, 0, 0, 0, 0,
                    16'h0000, 4'b1010, 4'b0010, 0, 0, 0, 16'h0, 0);
        tbl[11] = v(4'b0000, 64'h0, 1, 1, 0, 0, 0, 0, 1,
                    16'h0022, 4'b1000, 4'b0000, 0, 0, 0, 16'h0, 0);
        tbl[12] = v(4'b0000, 64'h0, 3, 1, 0, 0, 0, 0, 0,
                    16'h0033, 4'b0000, 4'b0000, 0, 0, 0, 16'h0, 0);
        tbl[13] = v(4'b0011, 64'h0044_0055, 1, 0, 0, 0, 0, 0, 0,
                    16'h0022, 4'b0011, 4'b0000, 1, 0, 0, 16'h0, 0);
        tbl[14] = v(4'b0000, 64'h0, 0, 0, 0, 0, 0, 0, 0,
                    16'h0055, 4'b0011, 4'b0000, 0, 0, 0, 16'h0, 0);
        tbl[15] = v(4'b0000, 64'h0, 0, 0, 1, 1, 16'h00AA, 0, 0,
                    16'h0055, 4'b0011, 4'b0000, 0, 1, 1, 16'h00AA, 0);
        tbl[16] = v(4'b0000, 64'h0, 0, 0, 1, 2, 16'h00BB, 0, 0,
                    16'h0055, 4'b0011, 4'b0000, 0, 1, 1, 16'h00AA, 0);
        tbl[17] = v(4'b0000, 64'h0, 0, 0, 0, 0, 0, 0, 0,
                    16'h0055, 4'b0011, 4'b0000, 0, 1, 1, 16'h00AA, 0);
        tbl[18] = v(4'b0000, 64'h0, 0, 0, 0, 0, 0, 1, 0,
                    16'h0055, 4'b0011, 4'b0000, 0, 1, 2, 16'h00BB, 0);
        tbl[19] = v(4'b0000, 64'h0, 0, 0, 0, 0, 0, 1, 0,
                    16'h0055, 4'b0011, 4'b0000, 0, 0, 0, 16'h0000, 0);

        // Reset state
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.io_in", 64'(io_in), 64'h0);
        chk("rst.fresh", 64'(fresh), 64'h0);
        chk("rst.ovr_in", 64'(ovr_in), 64'h0);
        chk("rst.itr", 64'(itr), 64'h0);
        chk("rst.ovr_out", 64'(ovr_out), 64'h0);
        chk_head("rst", 1'b0, 2'd0, 16'h0);
        rst = 1'b1;
        tick();

        foreach (tbl[i]) begin
            ext_in_vld  = tbl[i].vld;
            ext_in_data = tbl[i].din;
            addr_in     = tbl[i].ain;
            req_in      = tbl[i].req;
            out_en      = tbl[i].oen;
            addr_out    = tbl[i].aout;
            io_out      = tbl[i].dout;
            ext_out_rdy = tbl[i].rdy;
            clr_ovr     = tbl[i].clr;
            @(negedge clk);
            chk($sformatf("v%0d.io_in", i), 64'(io_in), 64'(tbl[i].e_io));
            tick();
            chk($sformatf("v%0d.fresh", i), 64'(fresh), 64'(tbl[i].e_fresh));
            chk($sformatf("v%0d.ovr_in", i), 64'(ovr_in), 64'(tbl[i].e_ovin));
            chk($sformatf("v%0d.itr", i), 64'(itr), 64'(tbl[i].e_itr));
            chk_head($sformatf("v%0d", i), tbl[i].e_ovld, tbl[i].e_oaddr, tbl[i].e_odata);
            chk($sformatf("v%0d.ovr_out", i), 64'(ovr_out), 64'(tbl[i].e_ovout));
        end
        idle_inputs();

        // Overflow: 4 accepted, 5th dropped (with clr_ovr the same cycle: set wins)
        for (int k = 0; k < 5; k++) begin
            out_en   = 1'b1;
            addr_out = 2'(k);
            io_out   = 16'h0100 + 16'(k);
            clr_ovr  = (k == 4);
            tick();
            chk($sformatf("ovf.w%0d.ovr_out", k), 64'(ovr_out), 64'(k == 4));
        end
        idle_inputs();
        chk_head("ovf.full", 1'b1, 2'd0, 16'h0100);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovf.clr.ovr_out", 64'(ovr_out), 64'h0);
        // Full with push and pop together: no drop
        out_en = 1'b1; addr_out = 2'd3; io_out = 16'h01FF; ext_out_rdy = 1'b1;
        tick();
        out_en = 1'b0;
        chk("ovf.pp.ovr_out", 64'(ovr_out), 64'h0);
        chk_head("ovf.pp", 1'b1, 2'd1, 16'h0101);
        tick();
        chk_head("ovf.d1", 1'b1, 2'd2, 16'h0102);
        tick();
        chk_head("ovf.d2", 1'b1, 2'd3, 16'h0103);
        tick();
        chk_head("ovf.d3", 1'b1, 2'd3, 16'h01FF);
        tick();
        chk_head("ovf.d4", 1'b0, 2'd0, 16'h0);
        idle_inputs();

        // Reset mid-traffic
        ext_in_vld = 4'b0010; ext_in_data = 64'h0077_0000;
        out_en = 1'b1; addr_out = 2'd1; io_out = 16'h0A01;
        tick();
        ext_in_vld = '0;
        addr_out = 2'd2; io_out = 16'h0A02;
        tick();
        out_en = 1'b0;
        addr_in = 2'd1;
        #1;
        chk("mid.pre.ovr_in", 64'(ovr_in), 64'b0010);
        chk_head("mid.pre", 1'b1, 2'd1, 16'h0A01);
        #2;
        rst = 1'b0;
        #1;
        chk("mid.io_in", 64'(io_in), 64'h0);
        chk("mid.fresh", 64'(fresh), 64'h0);
        chk("mid.ovr_in", 64'(ovr_in), 64'h0);
        chk("mid.itr", 64'(itr), 64'h0);
        chk_head("mid", 1'b0, 2'd0, 16'h0);
        tick();
        rst = 1'b1;
        tick();
        chk_head("mid.post", 1'b0, 2'd0, 16'h0);
        chk("mid.post.fresh", 64'(fresh), 64'h0);
        chk("mid.post.ovr_out", 64'(ovr_out), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
